// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation valve sequencer: FSM state codes,
// irrigation mode codes from the upstream mode encoder, and a mode helper.
`timescale 1ns/1ps
package irrigation_pkg;

  // FSM state codes, also presented on state_o for display/debug.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_WATER = 3'd2;
  localparam logic [2:0] ST_SOAK  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Mode codes {b1,b0} from the mode encoder.
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_SPR  = 2'b01;
  localparam logic [1:0] MODE_DRIP = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // True for the two modes that actually select a valve.
  function automatic logic is_run_mode(input logic [1:0] m);
    return (m == MODE_SPR) || (m == MODE_DRIP);
  endfunction

endpackage

// File: rtl/irrigation_tick_prescaler.sv
// Free-running timing prescaler: counts 0..TICK_DIV-1 and flags the wrap
// cycle with a single-clock tick. Never restarted by the sequencer FSM.
`timescale 1ns/1ps
module irrigation_tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  // Wrap counter; tick is high during the cycle the counter sits at LAST.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/irrigation_valve_sequencer.sv
// Irrigation valve sequencer: synchronizes mode/moisture/water-level inputs,
// then runs prime -> water -> soak cycles on the selected valve, with a
// water-loss fault lockout that needs operator deselection to clear.
// Optional build macro IRRIGATION_ALARM_BLINK_EN: alarm toggles every tick
// while in FAULT instead of being steady.
`timescale 1ns/1ps
module irrigation_valve_sequencer
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV      = 50000,
  parameter int PRIME_TICKS   = 20,
  parameter int SPR_ON_TICKS  = 300,
  parameter int DRIP_ON_TICKS = 1200,
  parameter int SOAK_TICKS    = 600,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       moisture_low,
  input  logic       water_ok,
  output logic       pump_on,
  output logic       valve_spr,
  output logic       valve_drip,
  output logic       alarm,
  output logic [2:0] state_o
);

  // A phase of N ticks expires on the tick where the counter reads N-1.
  localparam logic [CNT_W-1:0] LIM_PRIME = CNT_W'(PRIME_TICKS - 1);
  localparam logic [CNT_W-1:0] LIM_SPR   = CNT_W'(SPR_ON_TICKS - 1);
  localparam logic [CNT_W-1:0] LIM_DRIP  = CNT_W'(DRIP_ON_TICKS - 1);
  localparam logic [CNT_W-1:0] LIM_SOAK  = CNT_W'(SOAK_TICKS - 1);

  logic [1:0]       r_mode_s1, r_mode_s2;
  logic             r_moist_s1, r_moist_s2;
  logic             r_wok_s1, r_wok_s2;
  logic [2:0]       r_state;
  logic [1:0]       r_active_mode;
  logic [CNT_W-1:0] r_phase;
  logic             r_pump, r_spr, r_drip, r_alarm;

  logic             w_tick;
  logic [2:0]       w_state_nxt;
  logic [1:0]       w_active_nxt;
  logic [CNT_W-1:0] w_water_lim;
  logic             w_mode_changed;

  irrigation_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  // Two-flop synchronizers for all asynchronous field inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_s1  <= MODE_NONE;
      r_mode_s2  <= MODE_NONE;
      r_moist_s1 <= 1'b0;
      r_moist_s2 <= 1'b0;
      r_wok_s1   <= 1'b0;
      r_wok_s2   <= 1'b0;
    end else begin
      r_mode_s1  <= mode;
      r_mode_s2  <= r_mode_s1;
      r_moist_s1 <= moisture_low;
      r_moist_s2 <= r_moist_s1;
      r_wok_s1   <= water_ok;
      r_wok_s2   <= r_wok_s1;
    end
  end

  assign w_mode_changed = (r_mode_s2 != r_active_mode);
  assign w_water_lim    = (r_active_mode == MODE_SPR) ? LIM_SPR : LIM_DRIP;

  // Next-state decode; priority is water loss, then mode change, then expiry.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active_mode;
    case (r_state)
      ST_IDLE: begin
        if (is_run_mode(r_mode_s2) && r_moist_s2 && r_wok_s2) begin
          w_state_nxt  = ST_PRIME;
          w_active_nxt = r_mode_s2;
        end
      end
      ST_PRIME: begin
        if (!r_wok_s2)                        w_state_nxt = ST_FAULT;
        else if (w_mode_changed)              w_state_nxt = ST_IDLE;
        else if (w_tick && r_phase == LIM_PRIME) w_state_nxt = ST_WATER;
      end
      ST_WATER: begin
        if (!r_wok_s2)                          w_state_nxt = ST_FAULT;
        else if (w_mode_changed)                w_state_nxt = ST_IDLE;
        else if (w_tick && r_phase == w_water_lim) w_state_nxt = ST_SOAK;
      end
      ST_SOAK: begin
        if (!r_wok_s2) begin
          w_state_nxt = ST_FAULT;
        end else if (w_tick && r_phase == LIM_SOAK) begin
          w_state_nxt = (r_moist_s2 && !w_mode_changed) ? ST_PRIME : ST_IDLE;
        end
      end
      ST_FAULT: begin
        // Operator acknowledges by deselecting once water is back.
        if (r_wok_s2 && !is_run_mode(r_mode_s2)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched mode and phase counter; counter restarts on every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_active_mode <= MODE_NONE;
      r_phase       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_active_mode <= w_active_nxt;
      if (w_state_nxt != r_state) begin
        r_phase <= '0;
      end else if (w_tick) begin
        r_phase <= r_phase + CNT_W'(1);
      end
    end
  end

  // Registered drives decoded from the next state so they move with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pump <= 1'b0;
      r_spr  <= 1'b0;
      r_drip <= 1'b0;
    end else begin
      r_pump <= (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_WATER);
      r_spr  <= (w_state_nxt == ST_WATER) && (w_active_nxt == MODE_SPR);
      r_drip <= (w_state_nxt == ST_WATER) && (w_active_nxt != MODE_SPR);
    end
  end

  // Alarm drive: only ever asserted while the next state is FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
    end else if (w_state_nxt != ST_FAULT) begin
      r_alarm <= 1'b0;
`ifdef IRRIGATION_ALARM_BLINK_EN
    end else if (r_state != ST_FAULT) begin
      r_alarm <= 1'b1;
    end else if (w_tick) begin
      r_alarm <= ~r_alarm;
`endif
    end else begin
`ifdef IRRIGATION_ALARM_BLINK_EN
      r_alarm <= r_alarm;
`else
      r_alarm <= 1'b1;
`endif
    end
  end

  assign pump_on    = r_pump;
  assign valve_spr  = r_spr;
  assign valve_drip = r_drip;
  assign alarm      = r_alarm;
  assign state_o    = r_state;

endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Self-checking bench for irrigation_valve_sequencer with short timing
// parameters: table-driven start/no-start vectors plus directed sequences.
`timescale 1ns/1ps
module tb_irrigation_valve_sequencer;
  import irrigation_pkg::*;

  localparam int TD = 4;
  localparam int PT = 2;
  localparam int SP = 3;
  localparam int DR = 5;
  localparam int SK = 4;

  // Expected {state_o, pump_on, valve_spr, valve_drip, alarm}.
  localparam logic [6:0] O_IDLE  = {3'd0, 4'b0000};
  localparam logic [6:0] O_PRIME = {3'd1, 4'b1000};
  localparam logic [6:0] O_WSPR  = {3'd2, 4'b1100};
  localparam logic [6:0] O_WDRIP = {3'd2, 4'b1010};
  localparam logic [6:0] O_SOAK  = {3'd3, 4'b0000};
  localparam logic [6:0] O_FAULT = {3'd4, 4'b0001};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       moisture_low;
  logic       water_ok;
  logic       pump_on, valve_spr, valve_drip, alarm;
  logic [2:0] state_o;
  wire  [6:0] obs = {state_o, pump_on, valve_spr, valve_drip, alarm};

  int n_tests = 0;
  int n_fail  = 0;
  int inv_viol = 0;
  logic spr_seen = 1'b0;

  irrigation_valve_sequencer #(
    .TICK_DIV      (TD),
    .PRIME_TICKS   (PT),
    .SPR_ON_TICKS  (SP),
    .DRIP_ON_TICKS (DR),
    .SOAK_TICKS    (SK),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .moisture_low (moisture_low),
    .water_ok     (water_ok),
    .pump_on      (pump_on),
    .valve_spr    (valve_spr),
    .valve_drip   (valve_drip),
    .alarm        (alarm),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Output invariants watched on every falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((valve_spr && valve_drip) || ((valve_spr || valve_drip) && !pump_on))
        inv_viol++;
      if (valve_spr) spr_seen = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name,
                            output int cyc);
    cyc = 0;
    while (state_o !== st && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (state_o !== st) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, state_o=%0d required=%0d", name, state_o, st);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    mode         = MODE_NONE;
    moisture_low = 1'b0;
    water_ok     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] m;
    logic       moist;
    logic       wok;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int bad;
    int toggles;
    logic prev;

    vecs[0] = '{2'b00, 1'b1, 1'b1, O_IDLE};
    vecs[1] = '{2'b11, 1'b1, 1'b1, O_IDLE};
    vecs[2] = '{2'b01, 1'b0, 1'b1, O_IDLE};
    vecs[3] = '{2'b01, 1'b1, 1'b0, O_IDLE};
    vecs[4] = '{2'b10, 1'b0, 1'b1, O_IDLE};
    vecs[5] = '{2'b10, 1'b1, 1'b0, O_IDLE};
    vecs[6] = '{2'b01, 1'b1, 1'b1, O_PRIME};
    vecs[7] = '{2'b10, 1'b1, 1'b1, O_PRIME};

    do_reset();
    check("reset_state", obs, O_IDLE);

    // Start conditions from IDLE: nothing moves before the third edge.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      mode         = vecs[i].m;
      moisture_low = vecs[i].moist;
      water_ok     = vecs[i].wok;
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_before_latency", i), obs, O_IDLE);
      @(negedge clk);
      check($sformatf("vec%0d_after_latency", i), obs, vecs[i].exp);
    end

    // Sprinkler cycle with phase durations, repeating while dry.
    do_reset();
    mode = MODE_SPR; moisture_low = 1'b1; water_ok = 1'b1;
    wait_state(ST_PRIME, 10, "spr_to_prime", c);
    check("spr_prime_latency", c, 3);
    check("spr_prime_outputs", obs, O_PRIME);
    wait_state(ST_WATER, 20, "spr_to_water", c);
    check("spr_prime_len_in_range", (c >= (PT - 1) * TD + 1) && (c <= PT * TD), 1);
    check("spr_water_outputs", obs, O_WSPR);
    wait_state(ST_SOAK, 30, "spr_to_soak", c);
    check("spr_water_len", c, SP * TD);
    check("spr_soak_outputs", obs, O_SOAK);
    wait_state(ST_PRIME, 40, "spr_to_reprime", c);
    check("spr_soak_len", c, SK * TD);
    check("spr_reprime_outputs", obs, O_PRIME);

    // Asynchronous reset in the middle of WATER.
    wait_state(ST_WATER, 20, "rst_to_water", c);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_water", obs, O_IDLE);

    // Drip cycle; moisture satisfied mid-burst does not shorten it.
    do_reset();
    spr_seen = 1'b0;
    mode = MODE_DRIP; moisture_low = 1'b1; water_ok = 1'b1;
    wait_state(ST_PRIME, 10, "drip_to_prime", c);
    wait_state(ST_WATER, 20, "drip_to_water", c);
    check("drip_water_outputs", obs, O_WDRIP);
    moisture_low = 1'b0;
    wait_state(ST_SOAK, 40, "drip_to_soak", c);
    check("drip_water_len", c, DR * TD);
    wait_state(ST_IDLE, 40, "drip_to_idle", c);
    check("drip_soak_len", c, SK * TD);
    check("drip_idle_outputs", obs, O_IDLE);
    check("drip_no_sprinkler", spr_seen, 0);

    // Mode change mid-WATER aborts, then restarts with the new mode.
    do_reset();
    mode = MODE_SPR; moisture_low = 1'b1; water_ok = 1'b1;
    wait_state(ST_PRIME, 10, "mc_to_prime", c);
    wait_state(ST_WATER, 20, "mc_to_water", c);
    mode = MODE_DRIP;
    repeat (2) @(negedge clk);
    check("mc_still_water", obs, O_WSPR);
    @(negedge clk);
    check("mc_abort_idle", obs, O_IDLE);
    @(negedge clk);
    check("mc_restart_prime", obs, O_PRIME);
    wait_state(ST_WATER, 20, "mc_to_water2", c);
    check("mc_new_mode_drip", obs, O_WDRIP);

    // Water loss in SOAK beats a simultaneous mode change.
    do_reset();
    mode = MODE_SPR; moisture_low = 1'b1; water_ok = 1'b1;
    wait_state(ST_SOAK, 60, "wl_to_soak", c);
    water_ok = 1'b0;
    mode     = MODE_DRIP;
    repeat (2) @(negedge clk);
    check("wl_still_soak", obs, O_SOAK);
    @(negedge clk);
    check("wl_fault_entry", obs, O_FAULT);
    water_ok = 1'b1;
    mode     = MODE_SPR;
    bad = 0;
    toggles = 0;
    prev = alarm;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (state_o !== ST_FAULT || pump_on || valve_spr || valve_drip) bad++;
      if (alarm !== prev) toggles++;
      prev = alarm;
    end
    check("wl_fault_held_with_mode_selected", bad, 0);
`ifdef IRRIGATION_ALARM_BLINK_EN
    check("wl_alarm_blink_toggles", toggles, 3);
`else
    check("wl_alarm_steady_toggles", toggles, 0);
    check("wl_alarm_steady_level", alarm, 1);
`endif
    mode = MODE_NONE;
    repeat (2) @(negedge clk);
    check("wl_fault_before_ack", state_o, ST_FAULT);
    @(negedge clk);
    check("wl_ack_idle", obs, O_IDLE);

    check("invariant_violations", inv_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
